// File: rtl/sys_pkg.sv
// sys_pkg: shared matrix dimension, element width and drain FSM states
package sys_pkg;
  localparam int M = 3;
  localparam int W = 16;
  typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/result_drain_if.sv
// result_drain_if: matrix capture handshake in, element stream out
interface result_drain_if #(parameter int M = sys_pkg::M, parameter int W = sys_pkg::W);
  logic             mat_vld;
  logic [W*M*M-1:0] mat_in;
  logic             mat_rdy;
  logic [W-1:0]     c;
  logic             vld_out;
  logic             rdy_out;
  logic             last;
  modport master (output mat_vld, mat_in, rdy_out, input mat_rdy, c, vld_out, last);
  modport slave  (input mat_vld, mat_in, rdy_out, output mat_rdy, c, vld_out, last);
endinterface

// File: rtl/result_bank.sv
// result_bank: one M*M result matrix register with load/free, full flag and indexed read
module result_bank #(
  parameter int M  = sys_pkg::M,
  parameter int W  = sys_pkg::W,
  parameter int CW = (M > 1) ? $clog2(M) : 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_free,
  input  logic [W*M*M-1:0] i_data,
  input  logic [CW-1:0]    i_row,
  input  logic [CW-1:0]    i_col,
  output logic             o_full,
  output logic [W-1:0]     o_elem
);
  logic [W*M*M-1:0] r_data;
  logic             r_full;
  // load wins over free; the drain never frees the bank being loaded
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_free) begin
      r_full <= 1'b0;
    end
  end
  assign o_full = r_full;
  assign o_elem = r_data[W*(int'(i_row)*M+int'(i_col)) +: W];
endmodule

// File: rtl/result_drain.sv
// result_drain: ping-pong capture of result matrices, streamed out one element per transfer
// DRAIN_TRANSPOSE_EN selects column-major output order (row-major when undefined)
module result_drain
  import sys_pkg::*;
#(
  parameter int M = sys_pkg::M,
  parameter int W = sys_pkg::W
) (
  input logic           CLK,
  input logic           rst,
  result_drain_if.slave bus
);
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(M-1);
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_fast, r_slow, w_row, w_col;
  logic          r_rd_sel;
  logic [1:0]    w_full, w_load, w_free;
  logic [W-1:0]  w_elem [2];
  logic          w_cap, w_vld, w_xfer, w_last, w_last_xfer, w_other_full;
  assign bus.mat_rdy  = ~&w_full;
  assign w_cap        = bus.mat_vld && bus.mat_rdy;
  assign w_load       = w_cap ? (w_full[0] ? 2'b10 : 2'b01) : 2'b00;
  assign w_free       = w_last_xfer ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_vld        = r_state == DRAIN;
  assign w_xfer       = w_vld && bus.rdy_out;
  assign w_last       = w_vld && r_fast == LAST_IDX && r_slow == LAST_IDX;
  assign w_last_xfer  = w_xfer && w_last;
  assign w_other_full = w_full[~r_rd_sel];
`ifdef DRAIN_TRANSPOSE_EN
  assign w_row = r_fast;
  assign w_col = r_slow;
`else
  assign w_row = r_slow;
  assign w_col = r_fast;
`endif
  assign bus.vld_out = w_vld;
  assign bus.last    = w_last;
  assign bus.c       = w_vld ? w_elem[r_rd_sel] : '0;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    result_bank #(.M(M), .W(W), .CW(CW)) u_bank (
      .CLK(CLK), .rst(rst), .i_load(w_load[b]), .i_free(w_free[b]), .i_data(bus.mat_in),
      .i_row(w_row), .i_col(w_col), .o_full(w_full[b]), .o_elem(w_elem[b])
    );
  end
  // a same-cycle capture on the last transfer keeps DRAIN so the new matrix follows without a bubble
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = w_cap ? DRAIN : IDLE;
    else if (w_last_xfer) w_state_nxt = (w_other_full || w_cap) ? DRAIN : IDLE;
  end
  // state, element counters and the oldest-bank pointer
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_fast   <= '0;
      r_slow   <= '0;
      r_rd_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_fast <= (r_fast == LAST_IDX) ? '0 : r_fast + 1'b1;
        r_slow <= (r_fast != LAST_IDX) ? r_slow : (r_slow == LAST_IDX) ? '0 : r_slow + 1'b1;
      end
      if (w_last_xfer) r_rd_sel <= ~r_rd_sel;
      else if (w_cap && !(|w_full)) r_rd_sel <= 1'b0;
    end
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed checks of capture, drain order, stalls, ping-pong and reset (M=3, W=16)
module tb_result_drain;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  result_drain_if bus ();
  result_drain dut (.CLK(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [143:0] mk(input int ri, input int off);
    logic [143:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) m[16*(i*3+j) +: 16] = 16'(off + ri*i + j);
    return m;
  endfunction
  function automatic int ex(input int k, input int ri, input int off);
`ifdef DRAIN_TRANSPOSE_EN
    return off + ri*(k%3) + k/3;
`else
    return off + ri*(k/3) + k%3;
`endif
  endfunction
  task automatic drain9(input int ri, input int off, input string tag);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_vld%0d", tag, k), bus.vld_out, 1);
      chk($sformatf("%s_c%0d", tag, k), bus.c, ex(k, ri, off));
      chk($sformatf("%s_last%0d", tag, k), bus.last, k == 8);
      tick();
    end
  endtask
  task automatic drain18(input string tag);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("%s_vld%0d", tag, k), bus.vld_out, 1);
      chk($sformatf("%s_c%0d", tag, k), bus.c, ex(k%9, 3, k < 9 ? 0 : 100));
      chk($sformatf("%s_last%0d", tag, k), bus.last, k%9 == 8);
      tick();
      if (k == 0 && bus.mat_vld) begin
        bus.mat_vld = 1'b0;
        chk($sformatf("%s_full", tag), bus.mat_rdy, 0);
      end
    end
  endtask
  initial begin
    int k;
    bus.mat_vld = 1'b0;
    bus.mat_in  = '0;
    bus.rdy_out = 1'b0;
    tick();
    tick();
    chk("rst_vld", bus.vld_out, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_rdy", bus.mat_rdy, 1);
    rst = 1'b0;
    bus.rdy_out = 1'b1;
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(10, 0);
    chk("t1_rdy", bus.mat_rdy, 1);
    tick();
    bus.mat_vld = 1'b0;
    drain9(10, 0, "t1");
    chk("t1_idle", bus.vld_out, 0);
    chk("t1_idle_c", bus.c, 0);
    chk("t1_idle_rdy", bus.mat_rdy, 1);
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(10, 0);
    tick();
    bus.mat_vld = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 9; cyc++) begin
      bus.rdy_out = (cyc % 3 == 0);
      chk($sformatf("t2_vld%0d", cyc), bus.vld_out, 1);
      chk($sformatf("t2_c%0d", cyc), bus.c, ex(k, 10, 0));
      chk($sformatf("t2_last%0d", cyc), bus.last, k == 8);
      if (bus.rdy_out) k++;
      tick();
    end
    chk("t2_count", k, 9);
    chk("t2_idle", bus.vld_out, 0);
    bus.rdy_out = 1'b1;
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(3, 0);
    tick();
    bus.mat_in = mk(3, 100);
    chk("t3_rdy", bus.mat_rdy, 1);
    drain18("t3");
    chk("t3_idle", bus.vld_out, 0);
    bus.rdy_out = 1'b0;
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(3, 0);
    tick();
    bus.mat_in = mk(3, 100);
    tick();
    bus.mat_in = mk(3, 200);
    chk("t4_rdy", bus.mat_rdy, 0);
    tick();
    bus.mat_vld = 1'b0;
    chk("t4_hold", bus.c, 0);
    bus.rdy_out = 1'b1;
    drain18("t4");
    chk("t4_idle", bus.vld_out, 0);
    chk("t4_rdy_end", bus.mat_rdy, 1);
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(10, 0);
    tick();
    bus.mat_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_c4", bus.c, ex(4, 10, 0));
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_vld", bus.vld_out, 0);
    chk("t5_rst_c", bus.c, 0);
    chk("t5_rst_last", bus.last, 0);
    chk("t5_rst_rdy", bus.mat_rdy, 1);
    tick();
    rst = 1'b0;
    chk("t5_post_vld", bus.vld_out, 0);
    bus.mat_vld = 1'b1;
    bus.mat_in  = mk(3, 50);
    tick();
    bus.mat_vld = 1'b0;
    drain9(3, 50, "t5");
    chk("t5_idle", bus.vld_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter M, default 3, meaning matrix dimension (M x M results).
REQ-002 SHALL have parameter W, default 16, meaning result element width in bits.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mat_vld  input  1  mat_in holds a complete result matrix (driven by the array's completion flag).
REQ-006 SHALL have port mat_in  input  W*M*M  packed matrix; element [i][j] at bits [W*(i*M+j) +: W].
REQ-007 SHALL have port mat_rdy  output  1  drain can capture a matrix this cycle.
REQ-008 SHALL have port c  output  W  current output element.
REQ-009 SHALL have port vld_out  output  1  c is valid.
REQ-010 SHALL have port rdy_out  input  1  downstream accepts c.
REQ-011 SHALL have port last  output  1  c is the final element of its matrix.

Function
REQ-012 SHALL hold two matrix banks (ping-pong); mat_rdy = 1 whenever at least one bank is empty, combinationally from bank state only.
REQ-013 SHALL capture mat_in into the empty bank (bank 0 preferred if both empty) on a cycle with mat_vld && mat_rdy; mat_vld with mat_rdy low is ignored and nothing is captured.
REQ-014 SHALL drain banks in capture order (oldest first) using a two-state FSM: IDLE (vld_out = 0) and DRAIN (vld_out = 1).
REQ-015 SHALL transition IDLE -> DRAIN on the cycle after a capture, presenting element [0][0] (one-cycle latency from capture to vld_out).
REQ-016 SHALL count a transfer only on vld_out && rdy_out; row/col counters advance per transfer, col wraps M-1 -> 0 with row increment.
REQ-017 SHALL hold c, last and vld_out stable while vld_out && !rdy_out.
REQ-018 SHALL assert last exactly with element [M-1][M-1] (or its Configuration-defined equivalent).
REQ-019 SHALL, on the transfer of last, free the draining bank, reset counters to 0, and: if the other bank is full, stay in DRAIN and present its [0][0] the next cycle (no bubble); else go to IDLE.
REQ-020 SHALL allow a capture into the freed bank on the same cycle as the last transfer only if mat_rdy was already high due to the other bank; a bank freed this cycle is visible to mat_rdy the next cycle.
REQ-021 SHALL drive c = 0 and last = 0 whenever vld_out = 0.
REQ-022 SHALL pass elements unmodified (no width change, no arithmetic).

Reset
REQ-023 SHALL, on rst high (any time, including mid-drain), immediately mark both banks empty, clear counters, enter IDLE, drive c = 0, vld_out = 0, last = 0; mat_rdy = 1 after reset.
REQ-024 SHALL discard partially drained matrices on reset; no element is replayed.

Configuration
REQ-025 SHALL use macro DRAIN_TRANSPOSE_EN: defined -> column-major order ([0][0], [1][0], ... [M-1][M-1], row counter is the fast index); undefined -> row-major order.
REQ-026 SHALL keep last on element [M-1][M-1] in both modes and identical timing in both modes.

Structure
REQ-027 SHALL take W, default M, and the FSM state enum (IDLE, DRAIN) from shared package sys_pkg.
REQ-028 SHALL instantiate sub-module result_bank (one M*M register bank with load, free, full flag and indexed read) twice.

Verification (M=3, W=16)
REQ-029 SHALL verify: one matrix with [i][j] = 10*i+j, rdy_out held 1 -> vld_out the cycle after capture, c = 0,1,2,10,11,12,20,21,22 on 9 consecutive cycles, last only on 22, then IDLE.
REQ-030 SHALL verify: rdy_out toggled 1,0,0,1,... -> each c held while stalled; sequence unchanged, no drops or duplicates.
REQ-031 SHALL verify: two matrices captured back-to-back (values 0..8, then 100..108) -> mat_rdy low after second capture, 18 consecutive transfers with no bubble, last on 8 and 108.
REQ-032 SHALL verify: third mat_vld while both banks full -> ignored; output shows only first two matrices.
REQ-033 SHALL verify: rst asserted after 4 transfers -> outputs zero same cycle, mat_rdy = 1, next matrix drains from [0][0].
REQ-034 SHALL verify: DRAIN_TRANSPOSE_EN defined, [i][j] = 10*i+j -> c = 0,10,20,1,11,21,2,12,22, last on 22.
